// File: rtl/sdecode_pipe.sv
// Pipelined scalar instruction decoder: valid/ready input, registered control
// bundle with one cycle of latency, two-entry skid buffer and synchronous flush.
module sdecode_pipe #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENABLE_M = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] imm_o,
  output logic            imm_valid_o,
  output logic            reg_write_en_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            branch_o,
  output logic            jump_o,
  output logic            uses_rs1_o,
  output logic            uses_rs2_o,
  output logic [3:0]      alu_op_o,
  output logic [1:0]      mem_size_o,
  output logic            mem_unsigned_o,
  output logic [1:0]      result_src_o,
  output logic            muldiv_o,
  output logic [2:0]      md_op_o,
  output logic            illegal_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32= 7'b0011011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_SRA = 4'h7;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            imm_valid;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            uses_rs1;
    logic            uses_rs2;
    logic [3:0]      alu_op;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic [1:0]      result_src;
    logic            muldiv;
    logic [2:0]      md_op;
    logic            illegal;
  } bundle_t;

  // Base ALU operation selected by funct3 (no alternate encodings).
  function automatic logic [3:0] alu_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_f3 = 4'h0;
      3'b001:  alu_f3 = 4'h2;
      3'b010:  alu_f3 = 4'h3;
      3'b011:  alu_f3 = 4'h4;
      3'b100:  alu_f3 = 4'h5;
      3'b101:  alu_f3 = 4'h6;
      3'b110:  alu_f3 = 4'h8;
      default: alu_f3 = 4'h9;
    endcase
  endfunction

  bundle_t         dec_c;
  bundle_t         or_q;
  bundle_t         sr_q;
  logic            or_valid_q;
  logic            sr_valid_q;
  logic            in_ready_q;
  logic            accept_c;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic            ill;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  assign accept_c = in_valid_i & in_ready_q;

  // Combinational decode of the presented instruction word.
  always_comb begin
    dec_c     = '0;
    ill       = 1'b0;
    opc       = instr_i[6:0];
    f3        = instr_i[14:12];
    f7        = instr_i[31:25];
    imm_i     = XLEN'($signed(instr_i[31:20]));
    imm_s     = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
    imm_b     = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
    imm_u     = XLEN'($signed({instr_i[31:12], 12'b0}));
    imm_j     = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));
    dec_c.pc  = pc_i;
    dec_c.rs1 = instr_i[19:15];
    dec_c.rs2 = instr_i[24:20];
    dec_c.rd  = instr_i[11:7];

    if (opc == OPC_OP || (XLEN == 64 && opc == OPC_OP32)) begin
      dec_c.reg_write = 1'b1;
      dec_c.uses_rs1  = 1'b1;
      dec_c.uses_rs2  = 1'b1;
      if (f7 == 7'b0000001) begin
        if (ENABLE_M != 0) begin
          dec_c.muldiv = 1'b1;
          dec_c.md_op  = f3;
        end else begin
          ill = 1'b1;
        end
      end else if (f7 == 7'b0100000) begin
        if (f3 == 3'b000)      dec_c.alu_op = ALU_SUB;
        else if (f3 == 3'b101) dec_c.alu_op = ALU_SRA;
        else                   ill = 1'b1;
      end else if (f7 == 7'b0000000) begin
        dec_c.alu_op = alu_f3(f3);
      end else begin
        ill = 1'b1;
      end
    end else if (opc == OPC_OPIMM || (XLEN == 64 && opc == OPC_OPIMM32)) begin
      dec_c.reg_write = 1'b1;
      dec_c.uses_rs1  = 1'b1;
      dec_c.imm_valid = 1'b1;
      dec_c.imm       = imm_i;
      dec_c.alu_op    = (f3 == 3'b101 && instr_i[30]) ? ALU_SRA : alu_f3(f3);
    end else begin
      case (opc)
        OPC_LOAD: begin
          dec_c.reg_write    = 1'b1;
          dec_c.mem_read     = 1'b1;
          dec_c.uses_rs1     = 1'b1;
          dec_c.imm_valid    = 1'b1;
          dec_c.imm          = imm_i;
          dec_c.alu_op       = ALU_ADD;
          dec_c.mem_size     = f3[1:0];
          dec_c.mem_unsigned = f3[2];
          dec_c.result_src   = 2'b01;
          ill = (f3 == 3'b111) || (XLEN != 64 && (f3 == 3'b011 || f3 == 3'b110));
        end
        OPC_STORE: begin
          dec_c.mem_write = 1'b1;
          dec_c.uses_rs1  = 1'b1;
          dec_c.uses_rs2  = 1'b1;
          dec_c.imm_valid = 1'b1;
          dec_c.imm       = imm_s;
          dec_c.alu_op    = ALU_ADD;
          dec_c.mem_size  = f3[1:0];
          ill = f3[2] || (XLEN != 64 && f3 == 3'b011);
        end
        OPC_BRANCH: begin
          dec_c.branch    = 1'b1;
          dec_c.uses_rs1  = 1'b1;
          dec_c.uses_rs2  = 1'b1;
          dec_c.imm_valid = 1'b1;
          dec_c.imm       = imm_b;
          dec_c.alu_op    = f3[2] ? (4'hC + {2'b00, f3[1:0]}) : (4'hA + {3'b000, f3[0]});
          ill = (f3[2:1] == 2'b01);
        end
        OPC_LUI, OPC_AUIPC: begin
          dec_c.reg_write = 1'b1;
          dec_c.imm_valid = 1'b1;
          dec_c.imm       = imm_u;
          dec_c.alu_op    = ALU_ADD;
        end
        OPC_JAL: begin
          dec_c.reg_write  = 1'b1;
          dec_c.jump       = 1'b1;
          dec_c.imm_valid  = 1'b1;
          dec_c.imm        = imm_j;
          dec_c.result_src = 2'b10;
        end
        OPC_JALR: begin
          dec_c.reg_write  = 1'b1;
          dec_c.jump       = 1'b1;
          dec_c.uses_rs1   = 1'b1;
          dec_c.imm_valid  = 1'b1;
          dec_c.imm        = imm_i;
          dec_c.result_src = 2'b10;
          ill = (f3 != 3'b000);
        end
        default: ill = 1'b1;
      endcase
    end

    if (instr_i[1:0] != 2'b11) ill = 1'b1;

    // Illegal words keep only addresses and pc so the trap handler can locate them.
    if (ill) begin
      dec_c         = '0;
      dec_c.pc      = pc_i;
      dec_c.rs1     = instr_i[19:15];
      dec_c.rs2     = instr_i[24:20];
      dec_c.rd      = instr_i[11:7];
      dec_c.illegal = 1'b1;
    end
  end

  // Output register plus skid register; skid refills the output on drain, FIFO order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      or_valid_q <= 1'b0;
      sr_valid_q <= 1'b0;
      in_ready_q <= 1'b1;
      or_q       <= '0;
      sr_q       <= '0;
    end else if (flush_i) begin
      or_valid_q <= 1'b0;
      sr_valid_q <= 1'b0;
      in_ready_q <= 1'b1;
      or_q       <= '0;
      sr_q       <= '0;
    end else if (!or_valid_q || out_ready_i) begin
      if (sr_valid_q) begin
        or_q       <= sr_q;
        or_valid_q <= 1'b1;
        if (accept_c) begin
          sr_q       <= dec_c;
          sr_valid_q <= 1'b1;
          in_ready_q <= 1'b0;
        end else begin
          sr_valid_q <= 1'b0;
          in_ready_q <= 1'b1;
        end
      end else if (accept_c) begin
        or_q       <= dec_c;
        or_valid_q <= 1'b1;
      end else begin
        or_valid_q <= 1'b0;
      end
    end else if (accept_c) begin
      sr_q       <= dec_c;
      sr_valid_q <= 1'b1;
      in_ready_q <= 1'b0;
    end
  end

  assign in_ready_o     = in_ready_q;
  assign out_valid_o    = or_valid_q;
  assign pc_o           = or_q.pc;
  assign rs1_addr_o     = or_q.rs1;
  assign rs2_addr_o     = or_q.rs2;
  assign rd_addr_o      = or_q.rd;
  assign imm_o          = or_q.imm;
  assign imm_valid_o    = or_q.imm_valid;
  assign reg_write_en_o = or_q.reg_write;
  assign mem_read_o     = or_q.mem_read;
  assign mem_write_o    = or_q.mem_write;
  assign branch_o       = or_q.branch;
  assign jump_o         = or_q.jump;
  assign uses_rs1_o     = or_q.uses_rs1;
  assign uses_rs2_o     = or_q.uses_rs2;
  assign alu_op_o       = or_q.alu_op;
  assign mem_size_o     = or_q.mem_size;
  assign mem_unsigned_o = or_q.mem_unsigned;
  assign result_src_o   = or_q.result_src;
  assign muldiv_o       = or_q.muldiv;
  assign md_op_o        = or_q.md_op;
  assign illegal_o      = or_q.illegal;

endmodule

// File: doc/sdecode_pipe.md
# sdecode_pipe

Pipelined, parametrised successor to the single-cycle scalar decoder. It accepts instruction words over a valid/ready handshake and registers the decoded control bundle with one cycle of latency. A two-entry skid buffer keeps the input side fully pipelined under back-pressure. It adds RV64 widths, optional M-extension decode, illegal-instruction detection, PC pass-through and a synchronous flush for the fetch→decode→execute boundary.

## Interface
- XLEN, 32: datapath width, 32 or 64; sets immediate sign-extension width and legal load/store sizes.
- ENABLE_M, 0: 1 = decode MUL/DIV group (funct7 = 0000001 on opcode 0110011).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset; **asynchronous, active-high**.
- flush_i  in  1  discard all buffered instructions (synchronous).
- in_valid_i  in  1  instruction word valid.
- in_ready_o  out  1  decoder can accept a word.
- instr_i  in  32  instruction word.
- pc_i  in  XLEN  PC of instr_i.
- out_valid_o  out  1  decoded bundle valid.
- out_ready_i  in  1  execute stage accepts bundle.
- pc_o  out  XLEN  PC of the decoded instruction.
- rs1_addr_o, rs2_addr_o, rd_addr_o  out  5 each  instr[19:15], instr[24:20], instr[11:7].
- imm_o  out  XLEN  sign-extended immediate (I/S/B/U/J).
- imm_valid_o, reg_write_en_o, mem_read_o, mem_write_o, branch_o, jump_o, uses_rs1_o, uses_rs2_o  out  1 each.
- alu_op_o  out  4  ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, BEQ A, BNE B, BLT C, BGE D, BLTU E, BGEU F.
- mem_size_o  out  2  00 byte, 01 half, 10 word, 11 dword (XLEN=64 only).
- mem_unsigned_o  out  1  LBU/LHU/LWU.
- result_src_o  out  2  00 ALU, 01 memory, 10 PC+4.
- muldiv_o  out  1  M-extension op; funct3 carries the op on md_op_o.
- md_op_o  out  3  funct3 of the M-extension op.
- illegal_o  out  1  instruction not decodable under current parameters.

## Operation
- Combinational decode of instr_i follows the scalar decoder encodings above: R, OP-IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR. With XLEN=64 it also decodes OP-IMM-32/OP-32 (0011011/0111011) with the same alu_op.
- Decoded bundle and pc are captured into the output register; the bundle is never re-decoded.
- Illegal when any of:
  - unknown opcode;
  - LOAD funct3 ∈ {011 (legal only XLEN=64), 110 (legal only XLEN=64), 111};
  - STORE funct3 > 010 (011 legal only XLEN=64);
  - BRANCH funct3 ∈ {010, 011};
  - JALR funct3 ≠ 000;
  - R-type funct7 ∉ {0000000, 0100000, 0000001 if ENABLE_M}, or 0100000 with funct3 ∉ {000, 101};
  - instr[1:0] ≠ 11.
- Illegal bundle: illegal_o=1, every other control output 0, addresses/pc still passed. It is delivered in order like any other bundle.
- Skid buffer: output register (OR) plus skid register (SR). in_ready_o = !SR_full, registered.
  - Accept while OR empty or draining → into OR.
  - Accept while OR held (out_valid_o & !out_ready_i) → into SR.
  - When OR drains and SR is full, SR moves to OR.
  - Order is strictly FIFO.
- flush_i: at the next edge OR and SR are cleared, out_valid_o=0, in_ready_o=1. A word presented in the flush cycle is dropped. flush_i has priority over every other event.

## Timing
- Reset (async assert, sync release): out_valid_o=0, in_ready_o=1, all bundle outputs and pc_o = 0, SR empty.
- Latency: word accepted at edge N → out_valid_o high after edge N, bundle stable until the handshake completes.
- Throughput: 1/cycle with out_ready_i held high; no bubble on back-pressure release.
- out_valid_o and bundle remain stable while out_valid_o & !out_ready_i; never drop valid without a handshake or flush.
- in_ready_o falls the cycle after SR fills; it rises the cycle after SR drains.
- Simultaneous accept + drain with SR full: SR→OR, new word→SR, in_ready_o stays low only if SR remains occupied.
- Reset mid-transfer: buffered words are lost; there is no partial output.

## Test plan
- 0x002081B3 (ADD x3,x1,x2), out_ready=1 → one cycle later rs1=1, rs2=2, rd=3, alu_op=0, reg_write=1, uses_rs1/2=1, illegal=0.
- 0xFE000EE3 (BEQ x0,x0,-4) → imm_o=0xFFFFFFFC (XLEN=32) / 0xFFFFFFFFFFFFFFFC (XLEN=64), branch=1, alu_op=A, reg_write=0.
- 0x027302B3 (MUL x5,x6,x7): ENABLE_M=1 → muldiv=1, md_op=000, rd=5; ENABLE_M=0 → illegal=1, reg_write=0. Also 0xFFFFFFFF → illegal=1.
- Stream 4 words with out_ready=0 → first two accepted, in_ready low from cycle 3. Release out_ready → all 4 emerge in order, 1/cycle, bundle stable while stalled.
- Both registers full, assert flush_i with in_valid=1 → next cycle out_valid=0, in_ready=1, flushed and in-flight words never appear.
- Assert rst mid-stream (asynchronously, off-edge) → outputs zero immediately, in_ready=1. After release, the next word decodes normally.
